// File: rtl/hdlc_tx_bitstuffer_if.sv
// Byte-side handshake and serial line of the HDLC transmit back-end.
// The master drives frame bytes and controls; the slave (bit stuffer) drives the line.
interface hdlc_tx_bitstuffer_if;
  logic       Tx_Enable;
  logic [7:0] Tx_Byte;
  logic       Tx_ByteValid;
  logic       Tx_ByteLast;
  logic       Tx_ByteReady;
  logic       Tx_AbortFrame;
  logic       Tx;
  logic       TxEN;
  logic       Tx_Busy;
  logic       Tx_AbortedTrans;

  modport master (
    output Tx_Enable, Tx_Byte, Tx_ByteValid, Tx_ByteLast, Tx_AbortFrame,
    input  Tx_ByteReady, Tx, TxEN, Tx_Busy, Tx_AbortedTrans
  );

  modport slave (
    input  Tx_Enable, Tx_Byte, Tx_ByteValid, Tx_ByteLast, Tx_AbortFrame,
    output Tx_ByteReady, Tx, TxEN, Tx_Busy, Tx_AbortedTrans
  );
endinterface

// File: rtl/hdlc_tx_bitstuffer.sv
// HDLC transmit serialiser: opening flag, zero-stuffed LSB-first data, closing flag or abort.
// Every register describes the bit currently on the line; outputs are registered copies.
module hdlc_tx_bitstuffer #(
  parameter int STUFF_LEN = 5,
  parameter int MIN_GAP   = 2
) (
  input  logic                   Clk,
  input  logic                   Rst,
  hdlc_tx_bitstuffer_if.slave    bus
);
  localparam int         OW        = $clog2(STUFF_LEN + 1);
  localparam int         GW        = $clog2(MIN_GAP + 1);
  localparam logic [7:0] FLAG      = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'hFE;

  typedef enum logic [2:0] {
    IDLE, OPEN_FLAG, DATA, CLOSE_FLAG, ABORT, GAP
  } state_t;

  state_t          state, state_d;
  logic [2:0]      cnt, cnt_d;
  logic [7:0]      shreg, shreg_d;
  logic            cur_last, last_d;
  logic            stuffing, stuff_d;
  logic            exhausted, exh_d;
  logic [OW-1:0]   ones, ones_d;
  logic [GW-1:0]   gap_cnt, gap_d;
  logic            tx_q, tx_d, txen_q, txen_d, ready_q, ready_d;
  logic            busy_q, busy_d, abt_q, abt_d;
  logic            accept, abort_req, need_stuff, slot_end;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_last  <= 1'b0;
      stuffing  <= 1'b0;
      exhausted <= 1'b0;
      ones      <= '0;
      gap_cnt   <= GW'(MIN_GAP);
      tx_q      <= 1'b1;
      txen_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      abt_q     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cur_last  <= last_d;
      stuffing  <= stuff_d;
      exhausted <= exh_d;
      ones      <= ones_d;
      gap_cnt   <= gap_d;
      tx_q      <= tx_d;
      txen_q    <= txen_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      abt_q     <= abt_d;
    end
  end

  always_ff @(posedge Clk) begin
    shreg <= shreg_d;
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    shreg_d    = shreg;
    last_d     = cur_last;
    stuff_d    = stuffing;
    exh_d      = exhausted;
    gap_d      = gap_cnt;
    accept     = ready_q & bus.Tx_ByteValid;
    abort_req  = bus.Tx_AbortFrame & ((state == OPEN_FLAG) | (state == DATA));
    need_stuff = !stuffing && (ones == OW'(STUFF_LEN));
    // slot_end: last line slot belonging to the current byte (8th bit, or stuff 0 after it)
    slot_end   = (!stuffing && (cnt == 3'd7)) || (stuffing && exhausted);
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = OPEN_FLAG;
          cnt_d   = '0;
          shreg_d = bus.Tx_Byte;
          last_d  = bus.Tx_ByteLast;
          stuff_d = 1'b0;
          exh_d   = 1'b0;
        end
      end
      OPEN_FLAG: begin
        if (abort_req) begin
          state_d = ABORT;
          cnt_d   = '0;
        end else if (cnt == 3'd7) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      DATA: begin
        if (abort_req) begin
          state_d = ABORT;
          cnt_d   = '0;
          stuff_d = 1'b0;
          exh_d   = 1'b0;
        end else if (need_stuff) begin
          stuff_d = 1'b1;
          cnt_d   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (accept) begin
              shreg_d = bus.Tx_Byte;
              last_d  = bus.Tx_ByteLast;
              exh_d   = 1'b0;
            end else begin
              exh_d = 1'b1;
            end
          end
        end else if (slot_end) begin
          stuff_d = 1'b0;
          exh_d   = 1'b0;
          cnt_d   = '0;
          if (cur_last) begin
            state_d = CLOSE_FLAG;
          end else if (accept) begin
            shreg_d = bus.Tx_Byte;
            last_d  = bus.Tx_ByteLast;
          end else begin
            state_d = ABORT;
          end
        end else if (stuffing) begin
          stuff_d = 1'b0;
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      CLOSE_FLAG, ABORT: begin
        if (cnt == 3'd7) begin
          state_d = GAP;
          cnt_d   = '0;
          gap_d   = '0;
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(MIN_GAP - 1)) begin
          state_d = IDLE;
          gap_d   = GW'(MIN_GAP);
        end else begin
          gap_d = gap_cnt + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // the run of 1s spans byte boundaries; flags, aborts and stuff slots break it
    ones_d = (state_d == DATA && !stuff_d && shreg_d[cnt_d]) ? ones + OW'(1) : '0;
  end

  always_comb begin
    tx_d   = 1'b1;
    txen_d = 1'b0;
    case (state_d)
      OPEN_FLAG, CLOSE_FLAG: begin
        tx_d   = FLAG[cnt_d];
        txen_d = 1'b1;
      end
      ABORT: begin
        tx_d   = ABORT_PAT[cnt_d];
        txen_d = 1'b1;
      end
      DATA: begin
        tx_d   = !stuff_d && shreg_d[cnt_d];
        txen_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        txen_d = 1'b0;
      end
    endcase
    busy_d  = (state_d != IDLE);
    abt_d   = (state == ABORT) && (state_d == GAP);
    ready_d = ((state_d == IDLE) && bus.Tx_Enable && (gap_d == GW'(MIN_GAP))) ||
              ((state_d == DATA) && !last_d &&
               ((!stuff_d && (cnt_d == 3'd7)) || (stuff_d && exh_d)));
  end

  assign bus.Tx              = tx_q;
  assign bus.TxEN            = txen_q;
  assign bus.Tx_ByteReady    = ready_q;
  assign bus.Tx_Busy         = busy_q;
  assign bus.Tx_AbortedTrans = abt_q;
endmodule

// File: tb/tb_hdlc_tx_bitstuffer.sv
// Bench for hdlc_tx_bitstuffer: a line-bit scoreboard fed by a rule-level frame model,
// directed frames followed by randomized frames, aborts and underruns.
module tb_hdlc_tx_bitstuffer;
  localparam int STUFF_LEN = 5;
  localparam int MIN_GAP   = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  hdlc_tx_bitstuffer_if bus();

  hdlc_tx_bitstuffer #(.STUFF_LEN(STUFF_LEN), .MIN_GAP(MIN_GAP)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int         checks = 0;
  int         fails = 0;
  int         pulse_cnt = 0;
  bit         exp_q[$];
  bit         line[$];
  logic [7:0] fb[$];
  bit         prev_en = 0;
  bit         had_frame = 0;
  int         idle_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_octet(input logic [7:0] v);
    for (int i = 0; i < 8; i++) line.push_back(v[i]);
  endtask

  // Opening flag followed by the first n bytes of fb, LSB first, with a 0 after every 5th consecutive 1.
  task automatic build_data(input int n);
    int run;
    line.delete();
    push_octet(8'h7E);
    run = 0;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 8; i++) begin
        line.push_back(fb[b][i]);
        run = fb[b][i] ? run + 1 : 0;
        if (run == STUFF_LEN) begin
          line.push_back(1'b0);
          run = 0;
        end
      end
    end
  endtask

  // kind 0: complete frame; kind 1: abort while line bit number param is shown; kind 2: underrun after param bytes
  task automatic run_frame(input int kind, input int param);
    int idx, n_feed, bit_seen, pulses0, exp_pulse, delay;
    bit aborted, acc, done;
    if (kind == 2) begin
      build_data(param);
      push_octet(8'hFE);
    end else if (kind == 1) begin
      build_data(fb.size());
      while (line.size() > param) void'(line.pop_back());
      push_octet(8'hFE);
    end else begin
      build_data(fb.size());
      push_octet(8'h7E);
    end
    foreach (line[i]) exp_q.push_back(line[i]);
    n_feed    = (kind == 2) ? param : fb.size();
    exp_pulse = (kind == 0) ? 0 : 1;
    pulses0   = pulse_cnt;
    idx       = 0;
    bit_seen  = 0;
    aborted   = 0;
    done      = 0;
    delay     = $urandom_range(0, 2);
    @(posedge Clk); #1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (!aborted && idx < n_feed && cyc >= delay) begin
        bus.Tx_ByteValid = 1'b1;
        bus.Tx_Byte      = fb[idx];
        bus.Tx_ByteLast  = (kind != 2) && (idx == fb.size() - 1);
      end else begin
        bus.Tx_ByteValid = 1'b0;
        bus.Tx_ByteLast  = 1'b0;
      end
      bus.Tx_AbortFrame = 1'b0;
      if (bus.TxEN) bit_seen++;
      if (kind == 1 && !aborted && bus.TxEN && bit_seen == param) begin
        bus.Tx_AbortFrame = 1'b1;
        aborted = 1;
      end
      @(negedge Clk);
      acc = bus.Tx_ByteReady && bus.Tx_ByteValid;
      @(posedge Clk); #1;
      if (acc) idx++;
      done = (bit_seen > 0) && !bus.TxEN && (exp_q.size() == 0);
    end
    bus.Tx_ByteValid  = 1'b0;
    bus.Tx_ByteLast   = 1'b0;
    bus.Tx_AbortFrame = 1'b0;
    check("frame_done", done, 1);
    if (!done) exp_q.delete();
    @(negedge Clk); #1;
    check("aborted_pulses", pulse_cnt - pulses0, exp_pulse);
  endtask

  initial begin
    bit e;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        had_frame = 0;
        prev_en   = 0;
        idle_cnt  = 0;
      end else if (bus.TxEN) begin
        if (had_frame && !prev_en) check("min_gap", idle_cnt >= MIN_GAP, 1);
        check("busy_in_frame", bus.Tx_Busy, 1);
        check("bit_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_bit", bus.Tx, e);
        end
        had_frame = 1;
        prev_en   = 1;
        idle_cnt  = 0;
      end else begin
        check("idle_line", bus.Tx, 1);
        idle_cnt++;
        prev_en = 0;
      end
      if (Rst && bus.Tx_AbortedTrans) pulse_cnt++;
    end
  end

  initial begin
    int len, r, p0;
    bit ok;
    bus.Tx_Enable     = 1'b1;
    bus.Tx_Byte       = 8'h00;
    bus.Tx_ByteValid  = 1'b0;
    bus.Tx_ByteLast   = 1'b0;
    bus.Tx_AbortFrame = 1'b0;

    repeat (3) @(posedge Clk);
    #1;
    check("reset_tx", bus.Tx, 1);
    check("reset_txen", bus.TxEN, 0);
    check("reset_ready", bus.Tx_ByteReady, 0);
    check("reset_busy", bus.Tx_Busy, 0);
    check("reset_aborted", bus.Tx_AbortedTrans, 0);
    #1 Rst = 1'b1;
    repeat (3) @(posedge Clk);

    // single zero byte: 24 line bits
    fb = '{8'h00};
    run_frame(0, 0);
    ok = 0;
    for (int i = 0; i < MIN_GAP + 3 && !ok; i++) begin
      @(posedge Clk); #1;
      ok = bus.Tx_ByteReady;
    end
    check("ready_back", ok, 1);

    fb = '{8'hFF, 8'hFF};
    run_frame(0, 0);
    fb = '{8'h1F};
    run_frame(0, 0);
    fb = '{8'h12, 8'h34, 8'h56};
    run_frame(2, 1);
    fb = '{8'hA5, 8'h3C, 8'h81};
    run_frame(1, 21);
    fb = '{8'hFF, 8'h00};
    run_frame(0, 0);

    // abort request while idle is ignored
    p0 = pulse_cnt;
    @(posedge Clk); #1;
    bus.Tx_AbortFrame = 1'b1;
    @(posedge Clk); #1;
    bus.Tx_AbortFrame = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
      check("idle_abort_txen", bus.TxEN, 0);
      check("idle_abort_busy", bus.Tx_Busy, 0);
    end
    check("idle_abort_pulse", pulse_cnt - p0, 0);

    // disabled block refuses bytes
    bus.Tx_Enable = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    bus.Tx_ByteValid = 1'b1;
    bus.Tx_Byte      = 8'h00;
    bus.Tx_ByteLast  = 1'b1;
    repeat (6) begin
      check("disabled_ready", bus.Tx_ByteReady, 0);
      check("disabled_txen", bus.TxEN, 0);
      @(posedge Clk); #1;
    end
    bus.Tx_ByteValid = 1'b0;
    bus.Tx_ByteLast  = 1'b0;
    bus.Tx_Enable    = 1'b1;
    repeat (2) @(posedge Clk);

    // asynchronous reset in the middle of the data phase
    fb.delete();
    repeat (10) fb.push_back(8'h55);
    build_data(10);
    foreach (line[i]) exp_q.push_back(line[i]);
    @(posedge Clk); #1;
    bus.Tx_ByteValid = 1'b1;
    bus.Tx_Byte      = 8'h55;
    bus.Tx_ByteLast  = 1'b0;
    repeat (20) @(posedge Clk);
    #1;
    check("pre_reset_active", bus.TxEN, 1);
    #1 Rst = 1'b0;
    #1;
    check("async_rst_tx", bus.Tx, 1);
    check("async_rst_txen", bus.TxEN, 0);
    check("async_rst_ready", bus.Tx_ByteReady, 0);
    check("async_rst_busy", bus.Tx_Busy, 0);
    bus.Tx_ByteValid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b1;
    ok = 0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge Clk); #1;
      ok = bus.Tx_ByteReady;
    end
    check("ready_after_reset", ok, 1);
    check("idle_after_reset", bus.Tx_Busy, 0);

    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 6);
      fb.delete();
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 3);
        fb.push_back(r == 0 ? 8'hFF : (r == 1 ? 8'h00 : 8'($urandom)));
      end
      r = $urandom_range(0, 9);
      if (r < 6) begin
        run_frame(0, 0);
      end else if (r < 8) begin
        build_data(len);
        run_frame(1, $urandom_range(1, line.size()));
      end else if (len > 1) begin
        run_frame(2, $urandom_range(1, len - 1));
      end else begin
        run_frame(0, 0);
      end
    end

    repeat (5) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
